// File: rtl/lsu_aligner.sv
// Sequential load/store aligner between the M stage and a word-wide synchronous data memory.
// Latency: accept T -> rsp_valid T+2 for one beat, T+3 for a split access; every mack-low cycle adds one.
// Backpressure: req_ready only in IDLE; mreq and its beat fields are held until mack; rsp_valid is a 1-cycle pulse.
//
// Ports:
//   clk, rst                          rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready               request handshake (ready == IDLE)
//   req_we/req_size/req_se            store flag, size (0 byte .. 3 dword), sign-extend for loads
//   req_addr/req_wdata                byte address, store data in low bits
//   rsp_valid/rsp_rdata/rsp_err       completion pulse, extended load data, error flag
//   maddr/mreq/mwe/mwstb/mdatao       memory beat: word address, request, write, strobes, write data
//   mdatai/mack                       memory read data and beat completion
module lsu_aligner #(
    parameter int DW            = 32,
    parameter int AW            = 32,
    parameter bit MEM_BYTE0_MSB = 1'b1,
    parameter bit MISALIGN_EN   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [1:0]                 req_size,
    input  logic                       req_se,
    input  logic [AW-1:0]              req_addr,
    input  logic [DW-1:0]              req_wdata,
    output logic                       rsp_valid,
    output logic [DW-1:0]              rsp_rdata,
    output logic                       rsp_err,
    output logic [AW-$clog2(DW/8)-1:0] maddr,
    output logic                       mreq,
    output logic                       mwe,
    output logic [DW/8-1:0]            mwstb,
    output logic [DW-1:0]              mdatao,
    input  logic [DW-1:0]              mdatai,
    input  logic                       mack
);
    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);
    localparam int WW = AW - OW;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t          state, state_nxt;
    logic            we_q, se_q, split_q, err_q;
    logic [1:0]      size_q;
    logic [OW-1:0]   off_q;
    logic [WW-1:0]   waddr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   hold_q;     // beat0 read data, kept in offset order
    logic [DW-1:0]   rdata_q;

    // Internally every word is handled in "offset order": byte k of the
    // vector is the byte at word offset k. Converting to/from the memory
    // lane order is a self-inverse permutation.
    function automatic logic [DW-1:0] lane_swap(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < NB; k++) begin
            if (MEM_BYTE0_MSB) r[8*k +: 8] = w[8*(NB-1-k) +: 8];
            else               r[8*k +: 8] = w[8*k +: 8];
        end
        return r;
    endfunction

    function automatic logic [NB-1:0] stb_swap(input logic [NB-1:0] s);
        logic [NB-1:0] r;
        r = '0;
        for (int k = 0; k < NB; k++) begin
            if (MEM_BYTE0_MSB) r[k] = s[NB-1-k];
            else               r[k] = s[k];
        end
        return r;
    endfunction

    // Result byte i is the byte at offset o+i of the two-word window
    // {w1, w0}; then extend from bit 8*n-1 unless the load is full width.
    function automatic logic [DW-1:0] assemble(input logic [DW-1:0] w0,
                                               input logic [DW-1:0] w1,
                                               input int            o,
                                               input int            n,
                                               input logic          se);
        logic [DW-1:0] r;
        logic          sbit;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < n) begin
                if (o + i < NB) r[8*i +: 8] = w0[8*(o+i) +: 8];
                else            r[8*i +: 8] = w1[8*(o+i-NB) +: 8];
            end
        end
        sbit = r[8*n-1];
        for (int b = 0; b < DW; b++) begin
            if (se && (n < NB) && (b >= 8*n)) r[b] = sbit;
        end
        return r;
    endfunction

    // ---------------- request decode (used only in IDLE) ----------------
    int   req_n, req_off;
    logic req_illegal, req_misal, req_split, req_err;

    always_comb begin
        req_n       = 1 << req_size;
        req_off     = int'(req_addr[OW-1:0]);
        req_illegal = (DW == 32) && (req_size == 2'b11);
        req_misal   = (req_off & (req_n - 1)) != 0;
        req_split   = (req_off + req_n) > NB;
        req_err     = req_illegal || (req_misal && !MISALIGN_EN);
    end

    // ---------------- captured request geometry ----------------
    int cur_n, cur_off;

    always_comb begin
        cur_n   = 1 << size_q;
        cur_off = int'(off_q);
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = req_err ? RESP : BEAT0;
            BEAT0:   if (mack)      state_nxt = split_q ? BEAT1 : RESP;
            BEAT1:   if (mack)      state_nxt = RESP;
            RESP:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            se_q    <= 1'b0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        se_q    <= req_se;
                        size_q  <= req_size;
                        off_q   <= req_addr[OW-1:0];
                        waddr_q <= req_addr[AW-1:OW];
                        wdata_q <= req_wdata;
                        split_q <= req_split;
                        err_q   <= req_err;
                        // Cleared here so stores and errors respond with 0.
                        rdata_q <= '0;
                    end
                end
                BEAT0: begin
                    if (mack && !we_q) begin
                        if (split_q) hold_q  <= lane_swap(mdatai);
                        else         rdata_q <= assemble(lane_swap(mdatai), '0,
                                                         cur_off, cur_n, se_q);
                    end
                end
                BEAT1: begin
                    if (mack && !we_q)
                        rdata_q <= assemble(hold_q, lane_swap(mdatai),
                                            cur_off, cur_n, se_q);
                end
                default: ;
            endcase
        end
    end

    // ---------------- store beat formation ----------------
    // Beat0 carries offsets off..off+n-1 clipped to the word, beat1 the
    // remainder starting at offset 0.
    logic [DW-1:0] st_dat;
    logic [NB-1:0] st_stb;

    always_comb begin
        st_dat = '0;
        st_stb = '0;
        for (int k = 0; k < NB; k++) begin
            if (state == BEAT0 && k >= cur_off && k < cur_off + cur_n) begin
                st_stb[k]       = 1'b1;
                st_dat[8*k +: 8] = wdata_q[8*(k-cur_off) +: 8];
            end else if (state == BEAT1 && k < cur_off + cur_n - NB) begin
                st_stb[k]       = 1'b1;
                st_dat[8*k +: 8] = wdata_q[8*(k+NB-cur_off) +: 8];
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        rsp_err   = err_q;
        rsp_rdata = rdata_q;
        mreq      = (state == BEAT0) || (state == BEAT1);
        mwe       = mreq && we_q;
        maddr     = '0;
        if (state == BEAT0)      maddr = waddr_q;
        else if (state == BEAT1) maddr = waddr_q + WW'(1);
        mwstb     = mwe ? stb_swap(st_stb)  : '0;
        mdatao    = mwe ? lane_swap(st_dat) : '0;
    end
endmodule

// File: tb/tb_lsu_aligner.sv
module tb_lsu_aligner;
    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // main DUT (MISALIGN_EN = 1)
    logic        req_valid, req_ready, req_we, req_se;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [29:0] maddr;
    logic        mreq, mwe, mack;
    logic [3:0]  mwstb;
    logic [31:0] mdatao, mdatai;

    // second DUT (MISALIGN_EN = 0), shares request fields, memory always acks
    logic        n_req_valid, n_req_ready, n_rsp_valid, n_rsp_err;
    logic [31:0] n_rsp_rdata, n_mdatao, n_mdatai;
    logic [29:0] n_maddr;
    logic        n_mreq, n_mwe, n_mack;
    logic [3:0]  n_mwstb;
    assign n_mack   = n_mreq;
    assign n_mdatai = 32'h11223344;

    lsu_aligner #(.DW(32), .AW(32), .MEM_BYTE0_MSB(1'b1), .MISALIGN_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_se(req_se), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .maddr(maddr), .mreq(mreq), .mwe(mwe), .mwstb(mwstb),
        .mdatao(mdatao), .mdatai(mdatai), .mack(mack));

    lsu_aligner #(.DW(32), .AW(32), .MEM_BYTE0_MSB(1'b1), .MISALIGN_EN(1'b0)) dut_nm (
        .clk(clk), .rst(rst), .req_valid(n_req_valid), .req_ready(n_req_ready),
        .req_we(req_we), .req_size(req_size), .req_se(req_se), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(n_rsp_valid), .rsp_rdata(n_rsp_rdata),
        .rsp_err(n_rsp_err), .maddr(n_maddr), .mreq(n_mreq), .mwe(n_mwe),
        .mwstb(n_mwstb), .mdatao(n_mdatao), .mdatai(n_mdatai), .mack(n_mack));

    int checks = 0;
    int fails  = 0;

    // byte-addressed memory behind the main DUT
    logic [7:0] mem [logic [31:0]];

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // reference: little-endian load of n bytes starting at a, with extension
    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic se);
        logic [31:0] v;
        int          n;
        n = 1 << sz;
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(mem_rd(a + 32'(i))) << (8*i));
        if (n < 4 && se && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    // observed results of one access
    logic [29:0] b_addr [0:3];
    logic [3:0]  b_stb  [0:3];
    logic [31:0] b_dat  [0:3];
    logic        b_we   [0:3];
    int          nbeats, lat;
    logic [31:0] r_dat;
    logic        r_err;

    // expected beat contents from byte-address arithmetic
    logic [29:0] e_addr [0:1];
    logic [3:0]  e_stb  [0:1];
    logic [31:0] e_dat  [0:1];
    int          e_beats, e_lat;
    logic        e_err;

    task automatic model(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input int waits);
        int n, off;
        logic [31:0] ba;
        int lane, b;
        n   = 1 << sz;
        off = int'(a[1:0]);
        e_err   = (sz == 2'b11);
        e_beats = e_err ? 0 : ((off + n > 4) ? 2 : 1);
        e_lat   = e_err ? 1 : (1 + e_beats + waits * e_beats);
        e_addr[0] = a[31:2];
        e_addr[1] = a[31:2] + 30'd1;
        for (int k = 0; k < 2; k++) begin e_stb[k] = '0; e_dat[k] = '0; end
        if (w && !e_err) begin
            for (int i = 0; i < n; i++) begin
                ba   = a + 32'(i);
                b    = (ba[31:2] == a[31:2]) ? 0 : 1;
                lane = 3 - int'(ba[1:0]);
                e_stb[b][lane]       = 1'b1;
                e_dat[b][8*lane +: 8] = wd[8*i +: 8];
            end
        end
    endtask

    // Drive one request into the main DUT and act as its memory. Entered
    // and left just after a falling edge. Garbage is driven on req_* while
    // the unit is busy.
    task automatic access(input logic w, input logic [1:0] sz, input logic s,
                          input logic [31:0] a, input logic [31:0] wd, input int waits);
        int          wcnt;
        bit          inbeat;
        logic [29:0] held_a;
        logic [31:0] ba;
        nbeats = 0; lat = -1; r_dat = 'x; r_err = 1'bx;
        inbeat = 0; wcnt = 0; held_a = '0;
        checks++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL ready_before_req: got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_we = w; req_size = sz; req_se = s; req_addr = a; req_wdata = wd;
        @(posedge clk);
        for (int cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
            @(negedge clk);
            mack   = 1'b0;
            mdatai = $urandom;
            if (rsp_valid) begin
                lat = cyc; r_dat = rsp_rdata; r_err = rsp_err; req_valid = 1'b0;
            end else begin
                req_valid = 1'(($urandom));
                req_we    = 1'($urandom);
                req_size  = 2'($urandom);
                req_addr  = $urandom;
                req_wdata = $urandom;
                if (mreq) begin
                    if (!inbeat) begin
                        inbeat = 1; held_a = maddr; wcnt = 0;
                    end else begin
                        checks++;
                        if (maddr !== held_a) begin
                            fails++; $display("FAIL maddr_held: got %h want %h", maddr, held_a);
                        end
                    end
                    if (wcnt < waits) wcnt++;
                    else begin
                        mack = 1'b1; inbeat = 0;
                        if (nbeats < 4) begin
                            b_addr[nbeats] = maddr; b_stb[nbeats] = mwstb;
                            b_dat[nbeats] = mdatao; b_we[nbeats] = mwe;
                        end
                        nbeats++;
                        for (int k = 0; k < 4; k++) begin
                            ba = {maddr, 2'(k)};
                            if (mwe && mwstb[3-k]) mem[ba] = mdatao[8*(3-k) +: 8];
                            mdatai[8*(3-k) +: 8] = mem_rd(ba);
                        end
                    end
                end else begin
                    checks++;
                    if (inbeat || maddr !== 30'd0 || mwstb !== 4'd0 || mdatao !== 32'd0 || mwe !== 1'b0) begin
                        fails++;
                        $display("FAIL idle_outputs: inbeat=%0d maddr=%h mwstb=%b mdatao=%h mwe=%b want all 0",
                                 inbeat, maddr, mwstb, mdatao, mwe);
                    end
                end
            end
        end
        mack = 1'b0; req_valid = 1'b0;
        checks++;
        if (lat < 0) begin fails++; $display("FAIL rsp_timeout: no rsp_valid within 40 cycles"); end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++; $display("FAIL rsp_pulse: rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (req_ready !== 1'b1 || mreq !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
            rsp_rdata !== 32'd0 || maddr !== 30'd0 || mwstb !== 4'd0 || mdatao !== 32'd0 || mwe !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: ready=%b mreq=%b rv=%b err=%b rd=%h maddr=%h stb=%b do=%h we=%b",
                     req_ready, mreq, rsp_valid, rsp_err, rsp_rdata, maddr, mwstb, mdatao, mwe);
        end
    endtask

    task automatic test_directed;
        logic [31:0] e;
        for (int i = 0; i < 8; i++) mem[32'h100 + 32'(i)] = 8'(8'h11 * (i + 1));
        // aligned word load
        access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);
        checks++; if (r_dat !== 32'h44332211 || lat != 2 || nbeats != 1 || b_addr[0] !== 30'h40) begin
            fails++; $display("FAIL word_load: rd=%h lat=%0d beats=%0d ma=%h want 44332211/2/1/40", r_dat, lat, nbeats, b_addr[0]); end
        // split word load
        access(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0);
        checks++; if (r_dat !== 32'h66554433 || lat != 3 || nbeats != 2 || b_addr[0] !== 30'h40 || b_addr[1] !== 30'h41) begin
            fails++; $display("FAIL split_load: rd=%h lat=%0d beats=%0d ma=%h/%h want 66554433/3/2/40/41",
                              r_dat, lat, nbeats, b_addr[0], b_addr[1]); end
        // byte store
        access(1'b1, 2'd0, 1'b0, 32'h103, 32'hAB, 0);
        checks++; if (nbeats != 1 || b_stb[0] !== 4'b0001 || b_dat[0] !== 32'h000000AB || b_we[0] !== 1'b1 ||
                      r_err !== 1'b0 || lat != 2) begin
            fails++; $display("FAIL byte_store: beats=%0d stb=%b do=%h we=%b err=%b lat=%0d want 1/0001/000000ab/1/0/2",
                              nbeats, b_stb[0], b_dat[0], b_we[0], r_err, lat); end
        // split half store across words
        access(1'b1, 2'd1, 1'b0, 32'h0FF, 32'hBEEF, 0);
        checks++; if (nbeats != 2 || b_addr[0] !== 30'h3F || b_stb[0] !== 4'b0001 || b_dat[0] !== 32'h000000EF ||
                      b_addr[1] !== 30'h40 || b_stb[1] !== 4'b1000 || b_dat[1] !== 32'hBE000000) begin
            fails++; $display("FAIL half_store_split: beats=%0d %h/%b/%h %h/%b/%h want 2 3f/0001/000000ef 40/1000/be000000",
                              nbeats, b_addr[0], b_stb[0], b_dat[0], b_addr[1], b_stb[1], b_dat[1]); end
        // byte loads with sign/zero extension, first one with 3 wait states
        mem[32'h100] = 8'h00; mem[32'h101] = 8'h80; mem[32'h102] = 8'h00; mem[32'h103] = 8'h00;
        access(1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 3);
        checks++; if (r_dat !== 32'hFFFFFF80 || lat != 5) begin
            fails++; $display("FAIL byte_load_se_wait: rd=%h lat=%0d want ffffff80/5", r_dat, lat); end
        access(1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 0);
        checks++; if (r_dat !== 32'h00000080 || lat != 2) begin
            fails++; $display("FAIL byte_load_ze: rd=%h lat=%0d want 00000080/2", r_dat, lat); end
        // half load wrapping the top of the address space
        e = exp_load(32'hFFFFFFFF, 2'd1, 1'b0);
        access(1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0, 0);
        checks++; if (r_dat !== e || nbeats != 2 || b_addr[0] !== 30'h3FFFFFFF || b_addr[1] !== 30'h0) begin
            fails++; $display("FAIL wrap_load: rd=%h beats=%0d ma=%h/%h want %h/2/3fffffff/0",
                              r_dat, nbeats, b_addr[0], b_addr[1], e); end
        // illegal size on a 32-bit unit
        access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0);
        checks++; if (r_err !== 1'b1 || r_dat !== 32'd0 || nbeats != 0 || lat != 1) begin
            fails++; $display("FAIL illegal_size: err=%b rd=%h beats=%0d lat=%0d want 1/0/0/1", r_err, r_dat, nbeats, lat); end
    endtask

    task automatic nm_access(input logic [1:0] sz, input logic [31:0] a, output int l,
                             output logic [31:0] rd, output logic er, output bit saw);
        l = -1; rd = 'x; er = 1'bx; saw = 0;
        n_req_valid = 1'b1; req_we = 1'b0; req_size = sz; req_se = 1'b0; req_addr = a;
        @(posedge clk);
        for (int cyc = 1; cyc <= 10 && l < 0; cyc++) begin
            @(negedge clk);
            n_req_valid = 1'b0;
            if (n_mreq) saw = 1;
            if (n_rsp_valid) begin l = cyc; rd = n_rsp_rdata; er = n_rsp_err; end
        end
        @(negedge clk);
    endtask

    task automatic test_no_misalign;
        int l; logic [31:0] rd; logic er; bit saw;
        nm_access(2'd2, 32'h102, l, rd, er, saw);
        checks++; if (er !== 1'b1 || rd !== 32'd0 || saw || l != 1) begin
            fails++; $display("FAIL nm_misaligned: err=%b rd=%h mreq_seen=%0d lat=%0d want 1/0/0/1", er, rd, saw, l); end
        nm_access(2'd2, 32'h100, l, rd, er, saw);
        checks++; if (er !== 1'b0 || rd !== 32'h44332211 || !saw || l != 2) begin
            fails++; $display("FAIL nm_aligned: err=%b rd=%h mreq_seen=%0d lat=%0d want 0/44332211/1/2", er, rd, saw, l); end
    endtask

    task automatic test_reset_midop;
        bit saw_rsp;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd1; req_se = 1'b0; req_addr = 32'h0FF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (mreq !== 1'b1 || maddr !== 30'h3F) begin
            fails++; $display("FAIL rstmid_beat0: mreq=%b maddr=%h want 1/3f", mreq, maddr); end
        mack = 1'b1; mdatai = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        mack = 1'b0;
        checks++; if (mreq !== 1'b1 || maddr !== 30'h40) begin
            fails++; $display("FAIL rstmid_beat1: mreq=%b maddr=%h want 1/40", mreq, maddr); end
        rst = 1'b1;
        #1;
        checks++; if (mreq !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++; $display("FAIL rstmid_abort: mreq=%b ready=%b rv=%b want 0/1/0", mreq, req_ready, rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        saw_rsp = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid || mreq) saw_rsp = 1;
        end
        checks++; if (saw_rsp || req_ready !== 1'b1) begin
            fails++; $display("FAIL rstmid_quiet: activity=%0d ready=%b want 0/1", saw_rsp, req_ready); end
    endtask

    // back-to-back random traffic against the byte-level model
    task automatic test_random;
        logic        w, s;
        logic [1:0]  sz;
        logic [31:0] a, wd, e;
        int          waits;
        for (int it = 0; it < 300; it++) begin
            w     = 1'($urandom);
            s     = 1'($urandom);
            sz    = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a     = ($urandom_range(0, 9) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(0, 7)))
                                                : (32'h100 + 32'($urandom_range(0, 31)));
            wd    = $urandom;
            waits = $urandom_range(0, 2);
            e     = exp_load(a, sz, s);
            model(w, sz, a, wd, waits);
            access(w, sz, s, a, wd, waits);
            checks++; if (lat != e_lat || r_err !== e_err || nbeats != e_beats) begin
                fails++; $display("FAIL rnd_shape it=%0d: lat=%0d err=%b beats=%0d want %0d/%b/%0d",
                                  it, lat, r_err, nbeats, e_lat, e_err, e_beats); end
            if (!e_err && !w) begin
                checks++; if (r_dat !== e) begin
                    fails++; $display("FAIL rnd_load it=%0d a=%h sz=%0d se=%b: got %h want %h", it, a, sz, s, r_dat, e); end
            end
            if (e_err) begin
                checks++; if (r_dat !== 32'd0) begin
                    fails++; $display("FAIL rnd_err_data it=%0d: got %h want 0", it, r_dat); end
            end
            for (int b = 0; b < e_beats && b < nbeats; b++) begin
                checks++; if (b_addr[b] !== e_addr[b] || b_we[b] !== w || b_stb[b] !== e_stb[b] || b_dat[b] !== e_dat[b]) begin
                    fails++; $display("FAIL rnd_beat it=%0d b=%0d: %h/%b/%b/%h want %h/%b/%b/%h", it, b,
                                      b_addr[b], b_we[b], b_stb[b], b_dat[b], e_addr[b], w, e_stb[b], e_dat[b]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; n_req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_se = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; mack = 1'b0; mdatai = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset;
        test_directed;
        test_no_misalign;
        test_reset_midop;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
